// File: rtl/cpu_load_store_unit.sv
// Memory-stage load/store unit. Converts byte/half/word loads and stores into
// word-aligned data-cache transactions; sub-word stores use read-modify-write
// because the cache port has no byte enables. All outputs are registered.
module cpu_load_store_unit (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_store,
    input  logic [1:0]  i_width,
    input  logic        i_unsigned,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    input  logic        i_cacheable,
    output logic        o_ready,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_dcache_request,
    output logic        o_dcache_rw,
    output logic [31:0] o_dcache_address,
    output logic [31:0] o_dcache_wdata,
    output logic        o_dcache_cacheable,
    input  logic        i_dcache_ready,
    input  logic [31:0] i_dcache_rdata
);

    localparam logic [1:0] WidthByte = 2'b00;
    localparam logic [1:0] WidthHalf = 2'b01;
    localparam logic [1:0] WidthWord = 2'b10;
    localparam logic [1:0] WidthRsvd = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdLow,
        StWrReq,
        StWrLow,
        StDone
    } state_t;

    state_t      state_q, state_d;

    // Latched command
    logic        store_q, store_d;
    logic [1:0]  width_q, width_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;     // address bits [1:0]
    logic [15:0] wlow_q, wlow_d;     // low half of store data, enough for sub-word merge
    logic [31:0] data_q, data_d;     // word captured from the cache read

    // Output registers
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        rw_q, rw_d;
    logic [31:0] dc_addr_q, dc_addr_d;
    logic [31:0] dc_wdata_q, dc_wdata_d;
    logic        cacheable_q, cacheable_d;

    logic        bad_access;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_word;
    logic [31:0] merged_word;

    // Misaligned or reserved-width command seen in IDLE
    always_comb begin
        bad_access = 1'b0;
        case (i_width)
            WidthHalf: bad_access = i_address[0];
            WidthWord: bad_access = |i_address[1:0];
            WidthRsvd: bad_access = 1'b1;
            default:   bad_access = 1'b0;
        endcase
    end

    // Extract and extend the addressed lane of the captured word for loads
    always_comb begin
        byte_lane = data_q[{lane_q, 3'b000} +: 8];
        half_lane = data_q[{lane_q[1], 4'b0000} +: 16];
        case (width_q)
            WidthByte: load_word = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
            WidthHalf: load_word = {{16{half_lane[15] & ~uns_q}}, half_lane};
            default:   load_word = data_q;
        endcase
    end

    // Replace the addressed lane of the captured word with the store data
    always_comb begin
        merged_word = data_q;
        if (width_q == WidthByte) begin
            merged_word[{lane_q, 3'b000} +: 8] = wlow_q[7:0];
        end else begin
            merged_word[{lane_q[1], 4'b0000} +: 16] = wlow_q;
        end
    end

    // Next-state logic and next values of all registered outputs
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        width_d     = width_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        wlow_d      = wlow_q;
        data_d      = data_q;
        fault_d     = 1'b0;
        rdata_d     = rdata_q;
        dc_addr_d   = dc_addr_q;
        dc_wdata_d  = dc_wdata_q;
        cacheable_d = cacheable_q;

        case (state_q)
            StIdle: begin
                if (i_request) begin
                    store_d     = i_store;
                    width_d     = i_width;
                    uns_d       = i_unsigned;
                    lane_d      = i_address[1:0];
                    wlow_d      = i_wdata[15:0];
                    cacheable_d = i_cacheable;
                    if (bad_access) begin
                        state_d = StDone;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        dc_addr_d = {i_address[31:2], 2'b00};
                        if (i_store && (i_width == WidthWord)) begin
                            state_d    = StWrReq;
                            dc_wdata_d = i_wdata;
                        end else begin
                            state_d = StRdReq;
                        end
                    end
                end
            end
            StRdReq: begin
                if (i_dcache_ready) begin
                    data_d  = i_dcache_rdata;
                    state_d = StRdLow;
                end
            end
            StRdLow: begin
                // Registered cache may still show the previous ready; wait for it to fall
                if (!i_dcache_ready) begin
                    if (store_q) begin
                        state_d    = StWrReq;
                        dc_wdata_d = merged_word;
                    end else begin
                        state_d = StDone;
                        rdata_d = load_word;
                    end
                end
            end
            StWrReq: begin
                if (i_dcache_ready) begin
                    state_d = StWrLow;
                end
            end
            StWrLow: begin
                if (!i_dcache_ready) begin
                    state_d = StDone;
                    rdata_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StDone);
        req_d   = (state_d == StRdReq) || (state_d == StWrReq);
        rw_d    = (state_d == StWrReq);
    end

    // State, command and output registers; async reset clears everything
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            store_q     <= 1'b0;
            width_q     <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wlow_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            req_q       <= 1'b0;
            rw_q        <= 1'b0;
            dc_addr_q   <= '0;
            dc_wdata_q  <= '0;
            cacheable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            width_q     <= width_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            wlow_q      <= wlow_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            req_q       <= req_d;
            rw_q        <= rw_d;
            dc_addr_q   <= dc_addr_d;
            dc_wdata_q  <= dc_wdata_d;
            cacheable_q <= cacheable_d;
        end
    end

    assign o_ready            = ready_q;
    assign o_fault            = fault_q;
    assign o_rdata            = rdata_q;
    assign o_dcache_request   = req_q;
    assign o_dcache_rw        = rw_q;
    assign o_dcache_address   = dc_addr_q;
    assign o_dcache_wdata     = dc_wdata_q;
    assign o_dcache_cacheable = cacheable_q;

endmodule

// File: tb/tb_cpu_load_store_unit.sv
// Self-checking bench for cpu_load_store_unit: a behavioural data cache with
// random latency and stale-ready hold, plus a word-memory reference model.
module tb_cpu_load_store_unit;

    logic        clk, rst;
    logic        req, st, uns, cach;
    logic [1:0]  width;
    logic [31:0] addr, wdata;
    logic        rdy, flt;
    logic [31:0] rdata;
    logic        dc_req, dc_rw, dc_cach;
    logic [31:0] dc_addr, dc_wdata;
    logic        dc_ready;
    logic [31:0] dc_rdata;

    cpu_load_store_unit dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_request          (req),
        .i_store            (st),
        .i_width            (width),
        .i_unsigned         (uns),
        .i_address          (addr),
        .i_wdata            (wdata),
        .i_cacheable        (cach),
        .o_ready            (rdy),
        .o_fault            (flt),
        .o_rdata            (rdata),
        .o_dcache_request   (dc_req),
        .o_dcache_rw        (dc_rw),
        .o_dcache_address   (dc_addr),
        .o_dcache_wdata     (dc_wdata),
        .o_dcache_cacheable (dc_cach),
        .i_dcache_ready     (dc_ready),
        .i_dcache_rdata     (dc_rdata)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cach;
        int          start;
    } tx_t;

    tx_t         tx_q[$];
    int          low_q[$];
    logic [31:0] cache_mem [int];
    logic [31:0] ref_mem [int];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat_force = -1;
    int          hold_force = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        cache_mem[int'(a >> 2)] = v;
        ref_mem[int'(a >> 2)]   = v;
    endtask

    // Behavioural cache: random latency, ready held 1..3 cycles, rdata garbage otherwise
    initial begin : cache_model
        tx_t t;
        int  k;
        int  n;
        dc_ready = 1'b0;
        dc_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (dc_req === 1'b1) begin
                t.rw    = dc_rw;
                t.addr  = dc_addr;
                t.wdata = dc_wdata;
                t.cach  = dc_cach;
                t.start = cyc;
                tx_q.push_back(t);
                k = int'(t.addr >> 2);
                n = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
                repeat (n) begin @(posedge clk); #1; end
                dc_ready = 1'b1;
                if (t.rw) cache_mem[k] = t.wdata;
                else dc_rdata = cache_mem.exists(k) ? cache_mem[k] : $urandom;
                @(posedge clk); #1;
                check_val("req_drop", dc_req, 1'b0);
                n = (hold_force >= 0) ? hold_force : int'($urandom_range(0, 2));
                repeat (n) begin @(posedge clk); #1; end
                dc_ready = 1'b0;
                dc_rdata = $urandom;
                low_q.push_back(cyc);
            end
        end
    end

    task automatic wait_ready(output int rc);
        int b;
        b = 0;
        while (rdy !== 1'b1 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        check_val("ready_seen", rdy, 1'b1);
        rc = cyc;
    endtask

    // Issue one command (called #1 after an edge with the DUT idle) and check it
    task automatic do_op(input logic s, input logic [1:0] w, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, input logic c, output logic [31:0] got);
        int          k, sh, acc, rc, n_exp;
        logic [31:0] word, lane, mask, exp_rd, exp_new;
        logic        f, wr_only;
        k = int'(a >> 2);
        if (!ref_mem.exists(k)) set_word(a, $urandom);
        word    = ref_mem[k];
        f       = (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00);
        sh      = (w == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        mask    = (w == 2'b00) ? 32'hFF : 32'hFFFF;
        wr_only = s && (w == 2'b10);
        exp_rd  = '0;
        exp_new = word;
        n_exp   = 0;
        if (!f) begin
            if (!s) begin
                n_exp = 1;
                if (w == 2'b10) begin
                    exp_rd = word;
                end else begin
                    lane = (word >> sh) & mask;
                    if (!u && w == 2'b00 && lane[7]) lane = lane | 32'hFFFF_FF00;
                    if (!u && w == 2'b01 && lane[15]) lane = lane | 32'hFFFF_0000;
                    exp_rd = lane;
                end
            end else if (wr_only) begin
                n_exp   = 1;
                exp_new = wd;
            end else begin
                n_exp   = 2;
                exp_new = (word & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end
        ref_mem[k] = exp_new;
        tx_q.delete();
        low_q.delete();

        req = 1'b1; st = s; width = w; uns = u; addr = a; wdata = wd; cach = c;
        acc = cyc;
        @(posedge clk); #1;
        // Junk on the inputs while busy must be ignored
        req = 1'b0; st = 1'($urandom); width = 2'($urandom); uns = 1'($urandom);
        addr = $urandom; wdata = $urandom; cach = 1'($urandom);

        wait_ready(rc);
        got = rdata;
        check_val("fault", flt, f);
        check_val("rdata", rdata, exp_rd);
        check_val("tx_count", tx_q.size(), n_exp);
        if (f) check_val("fault_lat", rc, acc + 1);
        if (n_exp > 0 && tx_q.size() == n_exp && low_q.size() == n_exp) begin
            check_val("tx0_start", tx_q[0].start, acc + 1);
            check_val("tx0_addr", tx_q[0].addr, {a[31:2], 2'b00});
            check_val("tx0_cach", tx_q[0].cach, c);
            check_val("tx0_rw", tx_q[0].rw, wr_only);
            if (wr_only) check_val("tx0_wdata", tx_q[0].wdata, exp_new);
            if (n_exp == 2) begin
                check_val("tx1_start", tx_q[1].start, low_q[0] + 1);
                check_val("tx1_addr", tx_q[1].addr, {a[31:2], 2'b00});
                check_val("tx1_rw", tx_q[1].rw, 1'b1);
                check_val("tx1_wdata", tx_q[1].wdata, exp_new);
                check_val("tx1_cach", tx_q[1].cach, c);
            end
            check_val("ready_lat", rc, low_q[n_exp - 1] + 1);
        end
        @(posedge clk); #1;
        check_val("pulse_len", rdy, 1'b0);
        check_val("rdata_hold", rdata, exp_rd);
    endtask

    initial begin : stim
        logic [31:0] got, a, b;
        int          r1, acc2, bnd;
        logic        seen;
        rst = 1'b1; req = 1'b0; st = 1'b0; width = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0; cach = 1'b0;
        #12;
        check_val("rst_ready", rdy, 1'b0);
        check_val("rst_fault", flt, 1'b0);
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_dreq", dc_req, 1'b0);
        check_val("rst_daddr", dc_addr, 32'h0);
        check_val("rst_dwdata", dc_wdata, 32'h0);
        check_val("rst_dcach", {31'b0, dc_rw | dc_cach}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        set_word(32'h100, 32'hDEAD_BEEF);
        lat_force = 3;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, got);
        check_val("plan_word_load", got, 32'hDEAD_BEEF);
        lat_force = -1;
        set_word(32'h200, 32'h8011_2233);
        do_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 1'b0, got);
        check_val("plan_sbyte", got, 32'hFFFF_FF80);
        do_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1'b1, got);
        check_val("plan_ubyte", got, 32'h0000_0080);
        set_word(32'h300, 32'h1122_3344);
        do_op(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_ABCD, 1'b1, got);
        check_val("plan_half_store", cache_mem[int'(32'h300 >> 2)], 32'hABCD_3344);
        do_op(1'b0, 2'b10, 1'b0, 32'h401, 32'h0, 1'b0, got);
        do_op(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 1'b0, got);

        // Back-to-back word loads with stale ready held two extra cycles
        a = 32'h0000_0600; b = 32'h0000_0704;
        set_word(a, 32'h1357_9BDF); set_word(b, 32'h2468_ACE0);
        hold_force = 2;
        tx_q.delete(); low_q.delete();
        req = 1'b1; st = 1'b0; width = 2'b10; uns = 1'b0; addr = a; cach = 1'b1;
        @(posedge clk); #1;
        addr = b;
        wait_ready(r1);
        check_val("b2b_rdata0", rdata, 32'h1357_9BDF);
        check_val("b2b_fault0", flt, 1'b0);
        @(posedge clk); #1;
        acc2 = cyc;
        @(posedge clk); #1;
        req = 1'b0;
        wait_ready(r1);
        check_val("b2b_rdata1", rdata, 32'h2468_ACE0);
        check_val("b2b_txcount", tx_q.size(), 2);
        if (tx_q.size() == 2 && low_q.size() == 2) begin
            check_val("b2b_addr1", tx_q[1].addr, b);
            check_val("b2b_start1", tx_q[1].start, acc2 + 1);
            check_val("b2b_after_low", (tx_q[1].start > low_q[0]) ? 1 : 0, 1);
        end
        hold_force = -1;
        @(posedge clk); #1;

        // Async reset while a request is outstanding
        set_word(32'h500, 32'h55AA_1234);
        lat_force = 3;
        req = 1'b1; st = 1'b0; width = 2'b10; addr = 32'h500; cach = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        bnd = 0;
        while (dc_req !== 1'b1 && bnd < 20) begin @(posedge clk); #1; bnd++; end
        check_val("arst_req_up", dc_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_dreq", dc_req, 1'b0);
        check_val("arst_daddr", dc_addr, 32'h0);
        check_val("arst_dcach", dc_cach, 1'b0);
        check_val("arst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rdy === 1'b1) seen = 1'b1;
        end
        check_val("arst_no_ready", seen, 1'b0);
        lat_force = -1;
        do_op(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 1'b0, got);
        check_val("arst_reload", got, 32'h55AA_1234);

        // Randomized commands over a small address window to force reuse
        for (int i = 0; i < 150; i++) begin
            a = (($urandom_range(0, 1) != 0) ? 32'hFFFF_F000 : 32'h0000_1000)
                + 32'($urandom_range(0, 31));
            do_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
